camera_sampler: RTL and testbench

CAMERA_SAMPLER -- requirements
Module: camera_sampler

---
 rtl/camera_sampler.sv | 154 +++++++++++++++
 tb/tb_camera_sampler.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_sampler.sv
// Samples an 8-bit DVP-style camera bus into the clk_fast domain and
// assembles byte pairs into 16-bit pixels with line/frame position counters.
module camera_sampler #(
  parameter int SYNC_STAGES = 2,
  parameter int HW          = 11,
  parameter int VW          = 10
) (
  input  logic          clk_fast,
  input  logic          rst_fast,
  input  logic          cam_pclk,
  input  logic          cam_href,
  input  logic          cam_vsync,
  input  logic [7:0]    cam_data,
  output logic          pixel_valid,
  output logic [15:0]   pixel_data,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          frame_start,
  output logic          line_end
);

  typedef struct packed {
    logic       pclk;
    logic       href;
    logic       vsync;
    logic [7:0] data;
  } cam_t;

  typedef enum logic [1:0] {
    WAIT_VSYNC,
    IDLE,
    BYTE0,
    BYTE1
  } state_t;

  // All camera lines share one chain so href/vsync/data stay aligned with pclk.
  cam_t          r_sync [SYNC_STAGES];
  cam_t          w_sync;
  logic          w_pclk_rise;

  logic          r_pclk_prev;
  logic          r_rise;
  logic          r_smp_href;
  logic          r_smp_vsync;
  logic [7:0]    r_smp_data;

  state_t        r_state;
  logic          r_vsync_prev;
  logic          r_href_prev;
  logic [7:0]    r_high;
  logic          r_pixel_valid;
  logic [15:0]   r_pixel_data;
  logic [HW-1:0] r_hcount;
  logic [VW-1:0] r_vcount;
  logic          r_frame_start;
  logic          r_line_end;

  // NOTE: the synchronizer is an array of flops, not a RAM, so it is cleared
  // element by element; a pclk edge caught before reset must not survive it.
  always_ff @(posedge clk_fast) begin
    if (rst_fast) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= '{pclk: cam_pclk, href: cam_href, vsync: cam_vsync, data: cam_data};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_sync      = r_sync[SYNC_STAGES-1];
  assign w_pclk_rise = w_sync.pclk & ~r_pclk_prev;

  // NOTE: every register is updated with <= so all flops see the pre-edge
  // values; a blocking = here would let later statements read the new value.
  always_ff @(posedge clk_fast) begin
    if (rst_fast) begin
      r_pclk_prev <= 1'b0;
      r_rise      <= 1'b0;
      r_smp_href  <= 1'b0;
      r_smp_vsync <= 1'b0;
      r_smp_data  <= 8'h00;
    end else begin
      r_pclk_prev <= w_sync.pclk;
      r_rise      <= w_pclk_rise;
      r_smp_href  <= w_sync.href;
      r_smp_vsync <= w_sync.vsync;
      r_smp_data  <= w_sync.data;
    end
  end

  always_ff @(posedge clk_fast) begin
    if (rst_fast) begin
      r_state       <= WAIT_VSYNC;
      r_vsync_prev  <= 1'b0;
      r_href_prev   <= 1'b0;
      r_high        <= 8'h00;
      r_pixel_valid <= 1'b0;
      r_pixel_data  <= 16'h0000;
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_frame_start <= 1'b0;
      r_line_end    <= 1'b0;
    end else begin
      r_pixel_valid <= 1'b0;
      r_frame_start <= 1'b0;
      r_line_end    <= 1'b0;

      // hcount names the pixel just emitted, so it advances one cycle later.
      if (r_pixel_valid) r_hcount <= r_hcount + HW'(1);

      if (r_rise) begin
        r_vsync_prev <= r_smp_vsync;
        r_href_prev  <= r_smp_href;
        case (r_state)
          WAIT_VSYNC: begin
            if (r_vsync_prev && !r_smp_vsync) begin
              r_state       <= IDLE;
              r_frame_start <= 1'b1;
              r_hcount      <= '0;
              r_vcount      <= '0;
            end
          end
          default: begin
            if (r_smp_vsync) begin
              r_state <= WAIT_VSYNC;
            end else if (r_smp_href) begin
              if (r_state == BYTE1) begin
                r_pixel_data  <= {r_high, r_smp_data};
                r_pixel_valid <= 1'b1;
                r_state       <= BYTE0;
              end else begin
                // First byte of a pair; BYTE1 means one byte is held.
                r_high  <= r_smp_data;
                r_state <= BYTE1;
              end
            end else if (r_href_prev) begin
              r_line_end <= 1'b1;
              r_vcount   <= r_vcount + VW'(1);
              r_hcount   <= '0;
              r_state    <= IDLE;
            end
          end
        endcase
      end
    end
  end

  assign pixel_valid = r_pixel_valid;
  assign pixel_data  = r_pixel_data;
  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign frame_start = r_frame_start;
  assign line_end    = r_line_end;

endmodule

// File: tb/tb_camera_sampler.sv
// Scoreboard bench for camera_sampler: a byte-level camera model predicts the
// strobe sequence, and a monitor compares every DUT strobe plus its latency.
module tb_camera_sampler;

  localparam int S  = 3;
  localparam int HW = 3;
  localparam int VW = 3;

  logic          clk_fast  = 1'b0;
  logic          rst_fast  = 1'b1;
  logic          cam_pclk  = 1'b0;
  logic          cam_href  = 1'b0;
  logic          cam_vsync = 1'b0;
  logic [7:0]    cam_data  = 8'h00;
  logic          pixel_valid;
  logic [15:0]   pixel_data;
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic          frame_start;
  logic          line_end;

  camera_sampler #(.SYNC_STAGES(S), .HW(HW), .VW(VW)) dut (
    .clk_fast    (clk_fast),
    .rst_fast    (rst_fast),
    .cam_pclk    (cam_pclk),
    .cam_href    (cam_href),
    .cam_vsync   (cam_vsync),
    .cam_data    (cam_data),
    .pixel_valid (pixel_valid),
    .pixel_data  (pixel_data),
    .hcount      (hcount),
    .vcount      (vcount),
    .frame_start (frame_start),
    .line_end    (line_end)
  );

  // Posedges land on odd ns; all camera edges are kept on even ns.
  always #5 clk_fast = ~clk_fast;

  typedef enum logic [2:0] {EV_PIX = 3'b100, EV_FS = 3'b010, EV_LE = 3'b001} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [15:0] data;
    int          h;
    int          v;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Camera reference model, advanced once per pclk byte slot.
  bit          in_reset = 1'b1;
  bit          m_in_frame, m_vs_prev, m_href_prev, m_have;
  logic [7:0]  m_hi;
  logic [15:0] m_last_pix;
  int          m_line, m_pix;

  task automatic model_reset();
    m_in_frame  = 1'b0;
    m_vs_prev   = 1'b0;
    m_href_prev = 1'b0;
    m_have      = 1'b0;
    m_last_pix  = 16'h0000;
  endtask

  task automatic model_step(input bit h, input bit v, input logic [7:0] d);
    ev_t e;
    if (!m_in_frame) begin
      if (m_vs_prev && !v) begin
        m_in_frame = 1'b1;
        m_line = 0;
        m_pix  = 0;
        m_have = 1'b0;
        e = '{kind: EV_FS, data: m_last_pix, h: 0, v: 0};
        exp_q.push_back(e);
      end
    end else if (v) begin
      m_in_frame = 1'b0;
    end else if (h) begin
      if (m_have) begin
        m_last_pix = {m_hi, d};
        e = '{kind: EV_PIX, data: m_last_pix, h: m_pix % (1 << HW), v: m_line % (1 << VW)};
        exp_q.push_back(e);
        m_pix++;
        m_have = 1'b0;
      end else begin
        m_hi   = d;
        m_have = 1'b1;
      end
    end else if (m_href_prev) begin
      m_line++;
      m_pix  = 0;
      m_have = 1'b0;
      e = '{kind: EV_LE, data: m_last_pix, h: 0, v: m_line % (1 << VW)};
      exp_q.push_back(e);
    end
    m_vs_prev   = v;
    m_href_prev = h;
  endtask

  int t_lo = 20;
  int t_hi = 20;

  // One pclk period: signals launched at the falling edge, then low, high, fall.
  task automatic tick(input bit h, input bit v, input logic [7:0] d);
    cam_href  = h;
    cam_vsync = v;
    cam_data  = d;
    if (!in_reset) model_step(h, v, d);
    #(t_lo) cam_pclk = 1'b1;
    #(t_hi) cam_pclk = 1'b0;
  endtask

  task automatic line(input int nbytes);
    for (int i = 0; i < nbytes; i++) tick(1'b1, 1'b0, 8'($urandom));
    tick(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic new_frame();
    tick(1'b0, 1'b1, 8'h00);
    tick(1'b0, 1'b1, 8'h00);
    tick(1'b0, 1'b0, 8'h00);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk_fast);
    check("drain_pending_events", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pixel_valid"}, pixel_valid, 0);
    check({tag, "_frame_start"}, frame_start, 0);
    check({tag, "_line_end"},    line_end,    0);
    check({tag, "_pixel_data"},  pixel_data,  0);
    check({tag, "_hcount"},      hcount,      0);
    check({tag, "_vcount"},      vcount,      0);
  endtask

  // Record the edges that first see cam_pclk high, for the latency check.
  int cyc    = 0;
  bit last_p = 1'b0;
  bit rise_seen [65536];

  always @(posedge clk_fast) begin
    cyc++;
    rise_seen[cyc & 65535] = cam_pclk && !last_p;
    last_p = cam_pclk;
  end

  always @(negedge clk_fast) begin
    ev_t e;
    if (!rst_fast && (pixel_valid || frame_start || line_end)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {29'd0, pixel_valid, frame_start, line_end}, 0);
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind", {29'd0, pixel_valid, frame_start, line_end}, {29'd0, e.kind});
        check("pixel_data", pixel_data, e.data);
        check("hcount", hcount, e.h);
        check("vcount", vcount, e.v);
        if (e.kind == EV_PIX)
          check("pixel_latency", rise_seen[(cyc - (S + 1)) & 65535], 1);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #2;
    // Reset with a pclk rise inside it: must be ignored.
    tick(1'b1, 1'b0, 8'hAA);
    @(negedge clk_fast);
    check_reset_outputs("reset");
    rst_fast = 1'b0;
    in_reset = 1'b0;
    repeat (4) @(negedge clk_fast);

    // Bytes before any vsync: nothing may come out.
    line(4);
    drain();

    // Reference line 0x12 0x34 0x56 0x78.
    new_frame();
    tick(1'b1, 1'b0, 8'h12);
    tick(1'b1, 1'b0, 8'h34);
    tick(1'b1, 1'b0, 8'h56);
    tick(1'b1, 1'b0, 8'h78);
    tick(1'b0, 1'b0, 8'h00);
    drain();
    check("vcount_after_line", vcount, 1);

    // Odd-length line, then the next line restarts at hcount 0.
    line(3);
    line(2);
    drain();

    // vsync mid-line drops the partial pixel.
    line(2);
    tick(1'b1, 1'b0, 8'h9A);
    tick(1'b1, 1'b0, 8'hBC);
    tick(1'b1, 1'b0, 8'hDE);
    new_frame();
    line(2);
    drain();

    // Reset after one byte of a line, released with href still high.
    tick(1'b1, 1'b0, 8'h11);
    repeat (8) @(negedge clk_fast);
    drain();
    rst_fast = 1'b1;
    in_reset = 1'b1;
    model_reset();
    tick(1'b1, 1'b0, 8'h22);
    repeat (3) @(negedge clk_fast);
    check_reset_outputs("midline_reset");
    rst_fast = 1'b0;
    in_reset = 1'b0;
    tick(1'b1, 1'b0, 8'h33);
    tick(1'b1, 1'b0, 8'h44);
    tick(1'b1, 1'b0, 8'h55);
    tick(1'b0, 1'b0, 8'h00);
    new_frame();
    line(2);
    drain();

    // Fast pclk: 28 ns period, 14 ns high.
    t_lo = 14;
    t_hi = 14;
    new_frame();
    line(6);
    line(5);
    drain();

    // Randomized frames with random pclk timing; long lines wrap the counters.
    for (int f = 0; f < 6; f++) begin
      t_lo = 2 * $urandom_range(7, 12);
      t_hi = 2 * $urandom_range(7, 12);
      new_frame();
      for (int l = 0, nl = $urandom_range(3, 11); l < nl; l++) begin
        int nb;
        nb = $urandom_range(1, 20);
        if ($urandom_range(0, 12) == 0) begin
          for (int b = 0; b < nb / 2 + 1; b++) tick(1'b1, 1'b0, 8'($urandom));
          tick(1'b0, 1'b1, 8'h00);
          tick(1'b0, 1'b0, 8'h00);
        end else begin
          line(nb);
        end
        for (int g = 0, ng = $urandom_range(0, 2); g < ng; g++) tick(1'b0, 1'b0, 8'($urandom));
      end
      drain();
    end

    repeat (10) @(negedge clk_fast);
    drain();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
